branch_cmp_ctrl: RTL and testbench

Multicycle branch-resolution controller for the multicycle RV32I core. It accepts a conditional-branch request, registers the operands, and sequences the register comparison over fixed states. It then resolves taken/not-taken for BEQ/BNE/BLT/BGE/BLTU/BGEU and produces the next PC. It sits between the main control FSM and the PC register and replaces the always-true comparator path with a proper funct3-driven decision.

---
 rtl/branch_cmp_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_branch_cmp_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cmp_ctrl.sv
// ---------------------------------------------------------------------------
// branch_cmp_ctrl
//
// Multicycle branch-resolution controller for the multicycle RV32I core.
// A request is accepted in IDLE, and its operands are frozen in internal
// registers. Over the next three cycles the block produces the
// taken/not-taken decision and the resolved next PC:
//   CMP  : compare the latched operands into eq/lt/ltu flags
//   RES  : choose the condition by funct3, compute and register results
//   DONE : one-cycle completion pulse
// Results stay stable until the next request reaches its DONE state.
//
// Ports:
//   clk         in   1     system clock, rising edge
//   rst         in   1     asynchronous, active-high reset
//   start       in   1     request strobe, only looked at in IDLE
//   funct3      in   3     branch type (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   rs1_val     in   XLEN  first operand
//   rs2_val     in   XLEN  second operand
//   pc          in   XLEN  PC of the branch instruction
//   imm         in   XLEN  sign-extended B-type immediate
//   busy        out  1     high in every state except IDLE
//   done        out  1     one-cycle completion pulse
//   taken       out  1     branch decision
//   next_pc     out  XLEN  resolved next PC
//   illegal     out  1     funct3 was 010 or 011
//   misaligned  out  1     taken and next_pc[1:0] != 0
// ---------------------------------------------------------------------------
module branch_cmp_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            busy,
    output logic            done,
    output logic            taken,
    output logic [XLEN-1:0] next_pc,
    output logic            illegal,
    output logic            misaligned
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RES  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t state_q;
    state_t state_d;

    // Latched copy of the request; frozen for the whole operation.
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;

    // Comparison flags produced in CMP.
    logic eq_q;
    logic lt_q;
    logic ltu_q;

    // Registered results that drive the outputs.
    logic            taken_q;
    logic [XLEN-1:0] next_pc_q;
    logic            illegal_q;
    logic            misaligned_q;

    // Combinational result candidates used in RES.
    logic            cond_d;
    logic            illegal_d;
    logic [XLEN-1:0] target_d;
    logic            accept;

    assign accept = (state_q == S_IDLE) && start;

    // State register. Reset drops straight back to IDLE from any state,
    // so an aborted request can never reach DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. start is only honoured in IDLE; every other state
    // advances unconditionally, which gives the fixed three-cycle latency
    // and means a start while busy is simply ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CMP;
                end
            end
            S_CMP:   state_d = S_RES;
            S_RES:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode. Both outputs depend only on the state register, so
    // there is no path from any input to busy or done.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_IDLE:  busy = 1'b0;
            S_CMP:   busy = 1'b1;
            S_RES:   busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Request capture. Operands are only loaded on acceptance, so input
    // changes after the start cycle cannot disturb an in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            pc_q     <= '0;
            imm_q    <= '0;
        end else if (accept) begin
            funct3_q <= funct3;
            a_q      <= rs1_val;
            b_q      <= rs2_val;
            pc_q     <= pc;
            imm_q    <= imm;
        end
    end

    // Comparison stage. Registering the flags keeps the wide comparators
    // out of the same cycle as the PC adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
            ltu_q <= 1'b0;
        end else if (state_q == S_CMP) begin
            eq_q  <= (a_q == b_q);
            lt_q  <= ($signed(a_q) < $signed(b_q));
            ltu_q <= (a_q < b_q);
        end
    end

    // Condition select. The two unused encodings (010, 011) never take
    // and raise illegal instead, so the PC simply falls through.
    always_comb begin
        cond_d    = 1'b0;
        illegal_d = 1'b0;
        case (funct3_q)
            F3_BEQ:  cond_d = eq_q;
            F3_BNE:  cond_d = ~eq_q;
            F3_BLT:  cond_d = lt_q;
            F3_BGE:  cond_d = ~lt_q;
            F3_BLTU: cond_d = ltu_q;
            F3_BGEU: cond_d = ~ltu_q;
            default: begin
                cond_d    = 1'b0;
                illegal_d = 1'b1;
            end
        endcase
    end

    // Next PC candidate. Both sums wrap silently modulo 2^XLEN.
    always_comb begin
        target_d = pc_q + PC_STEP;
        if (cond_d) begin
            target_d = pc_q + imm_q;
        end
    end

    // Result registers. They load only in RES, so they change exactly on
    // the RES->DONE edge and hold until the next request gets there.
    // The fall-through target is always word aligned, so misalignment can
    // only come from a taken branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_q      <= 1'b0;
            next_pc_q    <= '0;
            illegal_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else if (state_q == S_RES) begin
            taken_q      <= cond_d;
            next_pc_q    <= target_d;
            illegal_q    <= illegal_d;
            misaligned_q <= cond_d & (target_d[1:0] != 2'b00);
        end
    end

    assign taken      = taken_q;
    assign next_pc    = next_pc_q;
    assign illegal    = illegal_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_branch_cmp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_cmp_ctrl
//
// Self-checking bench for branch_cmp_ctrl. The directed cases from the
// block description are run first, then a batch of randomized requests.
// The expected results come from a small behavioural model of the
// branch rules, and each request is checked cycle by cycle against the
// fixed CMP/RES/DONE/IDLE timeline.
// ---------------------------------------------------------------------------
module tb_branch_cmp_ctrl;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            busy;
    logic            done;
    logic            taken;
    logic [XLEN-1:0] next_pc;
    logic            illegal;
    logic            misaligned;

    int compare_count;
    int mismatch_count;

    // Model expectations for whatever the outputs should currently hold.
    logic            exp_taken;
    logic [XLEN-1:0] exp_next_pc;
    logic            exp_illegal;
    logic            exp_misaligned;

    branch_cmp_ctrl #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .funct3     (funct3),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .pc         (pc),
        .imm        (imm),
        .busy       (busy),
        .done       (done),
        .taken      (taken),
        .next_pc    (next_pc),
        .illegal    (illegal),
        .misaligned (misaligned)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something upstream stalls the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [XLEN-1:0] got,
                               input logic [XLEN-1:0] expected);
        compare_count++;
        if (got !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, expected);
        end
    endtask

    // Behavioural reference: the branch rules written as plain arithmetic.
    task automatic branchModel(input logic [2:0] f, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic [XLEN-1:0] p,
                               input logic [XLEN-1:0] i, output logic t,
                               output logic [XLEN-1:0] n, output logic il,
                               output logic mis);
        logic c;
        c  = 1'b0;
        il = 1'b0;
        case (f)
            3'b000:  c = (a == b);
            3'b001:  c = (a != b);
            3'b100:  c = ($signed(a) < $signed(b));
            3'b101:  c = ($signed(a) >= $signed(b));
            3'b110:  c = (a < b);
            3'b111:  c = (a >= b);
            default: il = 1'b1;
        endcase
        t   = c;
        n   = c ? (p + i) : (p + 32'd4);
        mis = c && (n % 4 != 0);
    endtask

    task automatic checkHeld(input string tag);
        checkOutput({tag, ".taken"}, XLEN'(taken), XLEN'(exp_taken));
        checkOutput({tag, ".next_pc"}, next_pc, exp_next_pc);
        checkOutput({tag, ".illegal"}, XLEN'(illegal), XLEN'(exp_illegal));
        checkOutput({tag, ".misaligned"}, XLEN'(misaligned), XLEN'(exp_misaligned));
    endtask

    task automatic scrambleInputs();
        funct3  = 3'($urandom);
        rs1_val = $urandom;
        rs2_val = $urandom;
        pc      = $urandom;
        imm     = $urandom;
    endtask

    // Issue one request and follow it through the whole timeline. With
    // noisy set, start stays high with junk operands from CMP through
    // DONE, which must all be ignored.
    task automatic applyStimulus(input string tag, input logic [2:0] f,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [XLEN-1:0] p, input logic [XLEN-1:0] i,
                                 input bit noisy);
        logic            t;
        logic [XLEN-1:0] n;
        logic            il;
        logic            mis;
        branchModel(f, a, b, p, i, t, n, il, mis);

        @(negedge clk);
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        pc      = p;
        imm     = i;
        start   = 1'b1;

        // N+1: CMP
        @(posedge clk);
        #1;
        start = noisy;
        scrambleInputs();
        checkOutput({tag, ".cmp.busy"}, XLEN'(busy), 1);
        checkOutput({tag, ".cmp.done"}, XLEN'(done), 0);
        checkHeld({tag, ".cmp"});

        // N+2: RES
        @(posedge clk);
        #1;
        scrambleInputs();
        checkOutput({tag, ".res.busy"}, XLEN'(busy), 1);
        checkOutput({tag, ".res.done"}, XLEN'(done), 0);
        checkHeld({tag, ".res"});

        // N+3: DONE with fresh results
        @(posedge clk);
        #1;
        exp_taken      = t;
        exp_next_pc    = n;
        exp_illegal    = il;
        exp_misaligned = mis;
        checkOutput({tag, ".done.busy"}, XLEN'(busy), 1);
        checkOutput({tag, ".done.done"}, XLEN'(done), 1);
        checkHeld({tag, ".done"});

        // N+4: IDLE, a start held through DONE must not have been taken
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput({tag, ".idle.busy"}, XLEN'(busy), 0);
        checkOutput({tag, ".idle.done"}, XLEN'(done), 0);
        checkHeld({tag, ".idle"});

        // One more idle cycle: no second done, nothing queued
        @(posedge clk);
        #1;
        checkOutput({tag, ".idle2.busy"}, XLEN'(busy), 0);
        checkOutput({tag, ".idle2.done"}, XLEN'(done), 0);
    endtask

    // Start a request, then hit reset in its RES cycle.
    task automatic abortInRes();
        @(negedge clk);
        funct3  = 3'b001;
        rs1_val = 32'h0000_0001;
        rs2_val = 32'h0000_0002;
        pc      = 32'h0000_0300;
        imm     = 32'h0000_0040;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        exp_taken      = 1'b0;
        exp_next_pc    = '0;
        exp_illegal    = 1'b0;
        exp_misaligned = 1'b0;
        checkOutput("abort.busy", XLEN'(busy), 0);
        checkOutput("abort.done", XLEN'(done), 0);
        checkHeld("abort");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("abort.hold.done", XLEN'(done), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checkOutput("abort.after.done", XLEN'(done), 0);
            checkOutput("abort.after.busy", XLEN'(busy), 0);
        end
        checkHeld("abort.after");
    endtask

    initial begin
        logic [2:0]      f;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] p;
        logic [XLEN-1:0] i;
        compare_count  = 0;
        mismatch_count = 0;
        rst     = 1'b1;
        start   = 1'b0;
        funct3  = '0;
        rs1_val = '0;
        rs2_val = '0;
        pc      = '0;
        imm     = '0;
        exp_taken      = 1'b0;
        exp_next_pc    = '0;
        exp_illegal    = 1'b0;
        exp_misaligned = 1'b0;

        #3;
        checkOutput("reset.busy", XLEN'(busy), 0);
        checkOutput("reset.done", XLEN'(done), 0);
        checkHeld("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed cases");
        applyStimulus("beq",  3'b000, 32'h0000_1234, 32'h0000_1234, 32'h100, 32'h20, 1'b0);
        applyStimulus("bne",  3'b001, 32'h0000_1234, 32'h0000_1234, 32'h100, 32'h20, 1'b0);
        applyStimulus("blt",  3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h100, 32'h20, 1'b0);
        applyStimulus("bltu", 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h100, 32'h20, 1'b0);
        applyStimulus("bge",  3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h100, 32'h20, 1'b0);
        applyStimulus("bgeu", 3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h100, 32'h20, 1'b0);
        applyStimulus("ill2", 3'b010, 32'h5, 32'h5, 32'h200, 32'h40, 1'b0);
        applyStimulus("ill3", 3'b011, 32'h5, 32'h6, 32'h200, 32'h40, 1'b0);
        applyStimulus("wrap", 3'b000, 32'h7, 32'h7, 32'hFFFF_FFF0, 32'h20, 1'b0);
        applyStimulus("misal", 3'b000, 32'h7, 32'h7, 32'hFFFF_FFF0, 32'h22, 1'b0);
        applyStimulus("busyprot", 3'b000, 32'h0000_1234, 32'h0000_1234, 32'h100, 32'h20, 1'b1);

        $display("[TB] reset during RES");
        abortInRes();
        applyStimulus("post_reset", 3'b000, 32'hABCD_0000, 32'hABCD_0000, 32'h400, 32'hFFFF_FFF8, 1'b0);

        $display("[TB] randomized requests");
        for (int r = 0; r < 60; r++) begin
            f = 3'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = $urandom;
                2:       b = a ^ 32'h8000_0000;
                default: b = a + 32'd1;
            endcase
            p = $urandom & 32'hFFFF_FFFC;
            i = ($urandom_range(0, 3) == 0) ? 32'($urandom) : ($urandom & 32'hFFFF_FFFC);
            applyStimulus($sformatf("rand%0d", r), f, a, b, p, i, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
